comparador_serial_ctrl: RTL and testbench



---
 rtl/comparador_pkg.sv | 40 ++++
 rtl/celda_serial.sv | 29 ++
 rtl/comparador_serial_ctrl.sv | 164 ++++++++++++++++
 tb/tb_comparador_serial_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// Shared types for the serial magnitude comparator: FSM state and relation encodings.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t     : controller state encoding (IDLE, RUN, DONE)
//   rel_t       : running relation between the operands (EQ, GT, LT)
//   rel_onehot  : relation -> {gt, eq, lt} one-hot decoding
//   cnt_width   : bit-position counter width, never less than 1
package comparador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      EQ = 2'b00,
      GT = 2'b01,
      LT = 2'b10
   } rel_t;

   // Result bus ordering is {gt, eq, lt}.
   function automatic logic [2:0] rel_onehot(input rel_t r);
      logic [2:0] oh;
      case (r)
         GT:      oh = 3'b100;
         LT:      oh = 3'b001;
         default: oh = 3'b010;
      endcase
      return oh;
   endfunction

   // $clog2(1) is 0, which would give a zero-width counter for N=1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/celda_serial.sv
// One-bit comparison cell, reused for every bit position of the serial comparator.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   a_bit, b_bit : the operand bits at the current position
//   rel_in       : relation accumulated over the lower bit positions
//   rel_out      : relation including this bit position
module celda_serial
   import comparador_pkg::*;
(
   input  logic a_bit,
   input  logic b_bit,
   input  rel_t rel_in,
   output rel_t rel_out
);

   // Bits are visited LSB first, so a differing bit overrides anything seen
   // below it; equal bits leave the lower-order verdict in place.
   always_comb begin
      rel_out = rel_in;
      if (a_bit && !b_bit) begin
         rel_out = GT;
      end else if (!a_bit && b_bit) begin
         rel_out = LT;
      end
   end

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Serial N-bit magnitude comparator: latches A/B on start, walks bits LSB first through one shared cell.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+N; one comparison per N+1 cycles.
// Backpressure: none; start is only accepted when not busy computing (IDLE, or the edge leaving DONE), otherwise dropped.
//
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   start      : comparison request
//   A, B       : operands, sampled only on the accepting edge
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, results valid from this cycle
//   gt, eq, lt : registered one-hot result, held until the next DONE or reset
module comparador_serial_ctrl
   import comparador_pkg::*;
#(
   parameter int N  = 3,
   parameter int CW = cnt_width(N)
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   ra;
   logic [N-1:0]   rb;
   rel_t           rel;
   rel_t           rel_nxt;
   logic           a_sel;
   logic           b_sel;
   logic           last_bit;
   logic           accept;
   logic           step;
   logic           load_res;

   // ------------------------------------------------------------------
   // Shared comparison cell, fed by the counter-selected operand bits
   // ------------------------------------------------------------------
   assign a_sel    = ra[cnt];
   assign b_sel    = rb[cnt];
   assign last_bit = (cnt == CW'(N - 1));

   celda_serial u_celda (
      .a_bit   (a_sel),
      .b_bit   (b_sel),
      .rel_in  (rel),
      .rel_out (rel_nxt)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   // The edge that leaves DONE may accept a new request directly. This is
   // what gives the N+1 cycle spacing when start is held high; a request
   // seen while the walk is in progress is simply dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = start ? RUN : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs and datapath enables
   // ------------------------------------------------------------------
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      step     = 1'b0;
      load_res = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
         end
         RUN: begin
            busy     = 1'b1;
            step     = 1'b1;
            load_res = last_bit;
         end
         DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            accept = start;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Operand, counter and relation registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra  <= '0;
         rb  <= '0;
         cnt <= '0;
         rel <= EQ;
      end else if (accept) begin
         ra  <= A;
         rb  <= B;
         cnt <= '0;
         rel <= EQ;
      end else if (step) begin
         rel <= rel_nxt;
         // Park on the top bit rather than wrapping; the next accept clears it.
         if (!last_bit) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Result registers: only the final RUN edge updates them, so they stay
   // stable for the whole of the following comparison.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gt <= 1'b0;
         eq <= 1'b0;
         lt <= 1'b0;
      end else if (load_res) begin
         {gt, eq, lt} <= rel_onehot(rel_nxt);
      end
   end

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Self-checking bench for comparador_serial_ctrl (N=3).
// Expected {gt,eq,lt} triples are queued as requests are driven and
// popped when the design raises done.
module tb_comparador_serial_ctrl;

   localparam int N = 3;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic         gt;
   logic         eq;
   logic         lt;

   int tests;
   int fails;

   logic [2:0] exp_q[$];

   comparador_serial_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .gt    (gt),
      .eq    (eq),
      .lt    (lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference relation, returned as {gt, eq, lt}.
   function automatic logic [2:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
      if (a > b) return 3'b100;
      if (a == b) return 3'b010;
      return 3'b001;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle start pulse; returns #1 after the accepting edge.
   task automatic start_cmp(input logic [N-1:0] a, input logic [N-1:0] b);
      A     = a;
      B     = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.push_back(model(a, b));
   endtask

   // Ticks until done is seen or the budget runs out.
   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      #2;
      tests++;
      if ({busy, done, gt, eq, lt} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 00000", {busy, done, gt, eq, lt});
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int  busy_cyc;
      int  lat;
      bit  seen;
      logic [2:0] e;
      start_cmp(3'd5, 3'd3);
      busy_cyc = 0;
      lat      = 0;
      seen     = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy) busy_cyc++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         tick();
         lat++;
      end
      tests++;
      if (!seen || lat != N) begin
         fails++;
         $display("FAIL basic_latency: seen=%0d got %0d cycles want %0d", seen, lat, N);
      end
      e = exp_q.pop_front();
      tests++;
      if ({gt, eq, lt} !== e) begin
         fails++;
         $display("FAIL basic_result: got %b want %b", {gt, eq, lt}, e);
      end
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL basic_idle_after: busy=%b done=%b want 0 0", busy, done);
      end
      tests++;
      if (busy_cyc != N + 1) begin
         fails++;
         $display("FAIL basic_busy_cycles: got %0d want %0d", busy_cyc, N + 1);
      end
   endtask

   task automatic test_msb_priority();
      int cyc;
      bit ok;
      logic [2:0] e;
      start_cmp(3'd3, 3'd4);
      wait_done(cyc, ok);
      e = exp_q.pop_front();
      tests++;
      if (!ok || {gt, eq, lt} !== e || e !== 3'b001) begin
         fails++;
         $display("FAIL msb_priority: ok=%0d got %b want %b", ok, {gt, eq, lt}, 3'b001);
      end
      tick();
   endtask

   task automatic test_eq_then_lt();
      int cyc;
      bit ok;
      bit held;
      logic [2:0] e;
      start_cmp(3'd4, 3'd4);
      wait_done(cyc, ok);
      e = exp_q.pop_front();
      tests++;
      if (!ok || {gt, eq, lt} !== e) begin
         fails++;
         $display("FAIL eq_result: ok=%0d got %b want %b", ok, {gt, eq, lt}, e);
      end
      tick();
      start_cmp(3'd2, 3'd6);
      held = 1'b1;
      ok   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if ({gt, eq, lt} !== 3'b010) held = 1'b0;
         tick();
      end
      tests++;
      if (!held) begin
         fails++;
         $display("FAIL result_hold_during_run: got %b want 010 until done", {gt, eq, lt});
      end
      e = exp_q.pop_front();
      tests++;
      if (!ok || {gt, eq, lt} !== e) begin
         fails++;
         $display("FAIL lt_result: ok=%0d got %b want %b", ok, {gt, eq, lt}, e);
      end
      tick();
   endtask

   task automatic test_exhaustive();
      int cyc;
      bit ok;
      int extra;
      logic [2:0] e;
      extra = 0;
      for (int ia = 0; ia < 8; ia++) begin
         for (int ib = 0; ib < 8; ib++) begin
            for (int w = 0; w < 10 && busy; w++) tick();
            start_cmp(3'(ia), 3'(ib));
            wait_done(cyc, ok);
            e = exp_q.pop_front();
            tests++;
            if (!ok || {gt, eq, lt} !== e) begin
               fails++;
               $display("FAIL exhaustive A=%0d B=%0d: ok=%0d got %b want %b",
                        ia, ib, ok, {gt, eq, lt}, e);
            end
            tick();
            if (done) extra++;
         end
      end
      tests++;
      if (extra != 0) begin
         fails++;
         $display("FAIL exhaustive_single_done: got %0d extra pulses want 0", extra);
      end
   endtask

   task automatic test_glitch();
      int ndone;
      logic [2:0] e;
      logic [2:0] got;
      start_cmp(3'd6, 3'd1);
      // First RUN cycle: scramble operands and raise start for one edge.
      A     = 3'd0;
      B     = 3'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      got   = 3'b000;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            ndone++;
            got = {gt, eq, lt};
         end
         tick();
      end
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL glitch_result: got %b want %b", got, e);
      end
      tests++;
      if (ndone != 1) begin
         fails++;
         $display("FAIL glitch_done_count: got %0d want 1", ndone);
      end
   endtask

   task automatic test_reset_midrun();
      int cyc;
      bit ok;
      int ndone;
      logic [2:0] e;
      start_cmp(3'd5, 3'd2);
      tick();
      rst = 1'b1;
      #1;
      tests++;
      if ({busy, done, gt, eq, lt} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_midrun_outputs: got %b want 00000", {busy, done, gt, eq, lt});
      end
      exp_q.delete();
      tick();
      rst   = 1'b0;
      ndone = 0;
      for (int i = 0; i < N + 3; i++) begin
         if (done || busy) ndone++;
         tick();
      end
      tests++;
      if (ndone != 0) begin
         fails++;
         $display("FAIL reset_midrun_no_done: got %0d active cycles want 0", ndone);
      end
      start_cmp(3'd7, 3'd7);
      wait_done(cyc, ok);
      e = exp_q.pop_front();
      tests++;
      if (!ok || cyc != N || {gt, eq, lt} !== e) begin
         fails++;
         $display("FAIL reset_then_eq: ok=%0d cyc=%0d got %b want %b after %0d",
                  ok, cyc, {gt, eq, lt}, e, N);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] pa[5] = '{3'd1, 3'd6, 3'd3, 3'd7, 3'd0};
      logic [N-1:0] pb[5] = '{3'd2, 3'd6, 3'd1, 3'd4, 3'd0};
      int cyc;
      bit ok;
      logic [2:0] e;
      A     = pa[0];
      B     = pb[0];
      start = 1'b1;
      tick();
      exp_q.push_back(model(pa[0], pb[0]));
      A = pa[1];
      B = pb[1];
      for (int i = 0; i < 4; i++) begin
         wait_done(cyc, ok);
         e = exp_q.pop_front();
         tests++;
         if (!ok || cyc != N || {gt, eq, lt} !== e) begin
            fails++;
            $display("FAIL back_to_back[%0d]: ok=%0d cyc=%0d got %b want %b",
                     i, ok, cyc, {gt, eq, lt}, e);
         end
         if (i == 3) start = 1'b0;
         tick();
         if (i < 3) begin
            // The edge just taken accepted pa[i+1]/pb[i+1].
            exp_q.push_back(model(pa[i+1], pb[i+1]));
            A = pa[i+2];
            B = pb[i+2];
         end
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL back_to_back_stop: busy=%b want 0", busy);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_basic();
      test_msb_priority();
      test_eq_then_lt();
      test_exhaustive();
      test_glitch();
      test_reset_midrun();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
